io_bus_arbiter: RTL

// Two-master round-robin arbiter for the memory-mapped IO slave port (din/addr/we/dout).

---
 rtl/io_bus_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-beat IO slave port.
// Serialises master commands and returns read data across the slave's one-cycle read latency.
module io_bus_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  // master 1
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  // IO slave
  output logic [AW-1:0] io_addr_o,
  output logic [DW-1:0] io_din_o,
  output logic          io_we_o,
  input  logic [DW-1:0] io_dout_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [AW-1:0] io_addr_q, io_addr_d;
  logic [DW-1:0] io_din_q, io_din_d;
  logic          io_we_q, io_we_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          busy_q, busy_d;
  logic          winner;

  // A tie goes to the master that did not win last; a lone requester always wins.
  always_comb begin
    if (m0_req_i && m1_req_i) winner = ~last_gnt_q;
    else                      winner = m1_req_i;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    io_addr_d  = io_addr_q;
    io_din_d   = io_din_q;
    io_we_d    = 1'b0;
    gnt_d      = 2'b00;
    rvalid_d   = 2'b00;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          io_addr_d      = winner ? m1_addr_i  : m0_addr_i;
          io_din_d       = winner ? m1_wdata_i : m0_wdata_i;
          io_we_d        = winner ? m1_we_i    : m0_we_i;
          gnt_d[winner]  = 1'b1;
          last_gnt_d     = winner;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        state_d = io_we_q ? IDLE : RDATA;
      end
      RDATA: begin
        // The slave loaded dout at the end of ISSUE; last_gnt_q still names the reader.
        if (last_gnt_q) m1_rdata_d = io_dout_i;
        else            m0_rdata_d = io_dout_i;
        rvalid_d[last_gnt_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      io_addr_q  <= '0;
      io_din_q   <= '0;
      io_we_q    <= 1'b0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      io_addr_q  <= io_addr_d;
      io_din_q   <= io_din_d;
      io_we_q    <= io_we_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign m0_gnt_o    = gnt_q[0];
  assign m1_gnt_o    = gnt_q[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign io_addr_o   = io_addr_q;
  assign io_din_o    = io_din_q;
  assign io_we_o     = io_we_q;
  assign busy_o      = busy_q;

endmodule
